// File: rtl/counter_arbiter_pkg.sv
// Shared types and default sizing for the interval-counter arbiter.
// Holds the FSM state encoding used by counter_arbiter.
package counter_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DefNumReq = 4;
  localparam int DefWidth  = 8;

endpackage

// File: rtl/counter_arbiter_rr.sv
// Combinational round-robin picker used by counter_arbiter.
// The search starts one past the previous owner and wraps at NumReq-1.
module rr_arbiter #(
  parameter int NumReq = 4,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last_grant,
  output logic [NumReq-1:0] grant,
  output logic [IdxW-1:0]   grant_idx,
  output logic              any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NumReq; off++) begin
      idx = (int'(last_grant) + off) % NumReq;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant_idx  = IdxW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Shares one down-counting interval timer among NumReq requesters.
// A granted requester's interval runs in RUN and ends with a one-cycle done pulse in DONE.
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int NumReq = DefNumReq,
  parameter int Width  = DefWidth
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NumReq-1:0]         req_valid,
  input  logic [NumReq*Width-1:0]   req_len,
  input  logic                      abort,
  output logic [NumReq-1:0]         req_ready,
  output logic [NumReq-1:0]         done,
  output logic                      busy,
  output logic [$clog2(NumReq)-1:0] grant_id,
  output logic [Width-1:0]          count
);

  localparam int IdxW = $clog2(NumReq);

  state_e            state_q, state_d;
  logic [Width-1:0]  count_q, count_d;
  logic [IdxW-1:0]   grant_id_q, grant_id_d;
  logic [IdxW-1:0]   last_grant_q, last_grant_d;

  logic [NumReq-1:0] arb_grant;
  logic [IdxW-1:0]   arb_idx;
  logic              arb_any;
  logic [Width-1:0]  win_len;

  rr_arbiter #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  assign win_len = req_len[int'(arb_idx)*Width +: Width];

  // Abort only acts on an interval in flight; in IDLE it never blocks a handshake.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    req_ready    = '0;
    done         = '0;
    case (state_q)
      IDLE: begin
        req_ready = arb_grant;
        if (arb_any) begin
          grant_id_d = arb_idx;
          count_d    = win_len;
          state_d    = (win_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q <= Width'(1)) begin
          state_d = DONE;
          count_d = '0;
        end else begin
          count_d = count_q - Width'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        count_d = '0;
        if (!abort) begin
          done         = {{(NumReq-1){1'b0}}, 1'b1} << grant_id_q;
          last_grant_d = grant_id_q;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      grant_id_q   <= '0;
      last_grant_q <= IdxW'(NumReq - 1);
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign count    = count_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Scenario-driven bench for counter_arbiter; expected done pulses are queued
// as {requester, edge} when stimulus is applied and popped when done rises.
module tb_counter_arbiter;

  localparam int NumReq = 4;
  localparam int Width  = 8;
  localparam int IdxW   = 2;

  typedef struct {
    int id;
    int edge_no;
  } exp_t;

  exp_t exp_q[$];

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NumReq-1:0]       req_valid;
  logic [NumReq*Width-1:0] req_len;
  logic                    abort;
  logic [NumReq-1:0]       req_ready;
  logic [NumReq-1:0]       done;
  logic                    busy;
  logic [IdxW-1:0]         grant_id;
  logic [Width-1:0]        count;

  int cyc    = 0;
  int checks = 0;
  int passed = 0;

  counter_arbiter #(
    .NumReq (NumReq),
    .Width  (Width)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_len   (req_len),
    .abort     (abort),
    .req_ready (req_ready),
    .done      (done),
    .busy      (busy),
    .grant_id  (grant_id),
    .count     (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Advance one clock and return at the falling edge, where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; abort = 1'b0; req_valid = '0; req_len = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (count !== '0) $display("[TB] FAIL reset_count got %0d want 0", count); else passed++;
    checks++; if (grant_id !== '0) $display("[TB] FAIL reset_grant_id got %0d want 0", grant_id); else passed++;
    checks++; if (done !== '0) $display("[TB] FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (req_ready !== '0) $display("[TB] FAIL reset_ready got %b want 0", req_ready); else passed++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_priority();
    exp_t e; logic [NumReq-1:0] oh;
    req_valid = 4'b1001; req_len = '0;
    req_len[0*Width +: Width] = 8'd1; req_len[3*Width +: Width] = 8'd1;
    #1;
    checks++; if (req_ready !== 4'b0001) $display("[TB] FAIL prio_ready got %b want 0001", req_ready); else passed++;
    exp_q.push_back('{id: 0, edge_no: cyc + 3});
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) begin
        checks++; if (grant_id !== 2'd0) $display("[TB] FAIL prio_grant got %0d want 0", grant_id); else passed++;
        req_valid = '0;
      end
      if (done !== '0) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL prio_done unexpected %b at edge %0d", done, cyc + 1);
        else begin
          e = exp_q.pop_front(); oh = '0; oh[e.id] = 1'b1;
          if (done !== oh || cyc + 1 != e.edge_no) $display("[TB] FAIL prio_done got %b@%0d want %b@%0d", done, cyc + 1, oh, e.edge_no);
          else passed++;
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin $display("[TB] FAIL prio_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end else passed++;
  endtask

  task automatic test_single();
    exp_t e; logic [NumReq-1:0] oh; logic [Width-1:0] exp_cnt;
    req_valid = 4'b0010; req_len = '0; req_len[1*Width +: Width] = 8'd3;
    #1;
    checks++; if (req_ready !== 4'b0010) $display("[TB] FAIL single_ready got %b want 0010", req_ready); else passed++;
    exp_q.push_back('{id: 1, edge_no: cyc + 5});
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) begin
        checks++; if (grant_id !== 2'd1) $display("[TB] FAIL single_grant got %0d want 1", grant_id); else passed++;
        req_valid = '0;
      end
      if (k <= 4) begin
        exp_cnt = (k < 3) ? Width'(3 - k) : '0;
        checks++; if (count !== exp_cnt) $display("[TB] FAIL single_count k=%0d got %0d want %0d", k, count, exp_cnt); else passed++;
        checks++; if (busy !== (k <= 3)) $display("[TB] FAIL single_busy k=%0d got %b want %b", k, busy, (k <= 3)); else passed++;
      end
      if (done !== '0) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL single_done unexpected %b at edge %0d", done, cyc + 1);
        else begin
          e = exp_q.pop_front(); oh = '0; oh[e.id] = 1'b1;
          if (done !== oh || cyc + 1 != e.edge_no) $display("[TB] FAIL single_done got %b@%0d want %b@%0d", done, cyc + 1, oh, e.edge_no);
          else passed++;
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin $display("[TB] FAIL single_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end else passed++;
  endtask

  task automatic test_abort();
    exp_t e; logic [NumReq-1:0] oh;
    req_valid = 4'b0010; req_len = '0; req_len[1*Width +: Width] = 8'd2;
    #1;
    checks++; if (req_ready !== 4'b0010) $display("[TB] FAIL abort_ready got %b want 0010", req_ready); else passed++;
    tick();
    req_valid = '0;
    tick();
    checks++; if (count !== 8'd1) $display("[TB] FAIL abort_count1 got %0d want 1", count); else passed++;
    abort = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_idle got busy %b want 0", busy); else passed++;
    checks++; if (count !== '0) $display("[TB] FAIL abort_count got %0d want 0", count); else passed++;
    checks++; if (done !== '0) $display("[TB] FAIL abort_done got %b want 0", done); else passed++;
    abort = 1'b0;
    tick();
    checks++; if (done !== '0) $display("[TB] FAIL abort_late_done got %b want 0", done); else passed++;
    // Abort held high in IDLE must not stop this handshake.
    req_valid = 4'b0110; abort = 1'b1;
    req_len[1*Width +: Width] = 8'd1; req_len[2*Width +: Width] = 8'd1;
    #1;
    checks++; if (req_ready !== 4'b0100) $display("[TB] FAIL abort_next_ready got %b want 0100", req_ready); else passed++;
    exp_q.push_back('{id: 2, edge_no: cyc + 3});
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) begin
        checks++; if (grant_id !== 2'd2) $display("[TB] FAIL abort_next_grant got %0d want 2", grant_id); else passed++;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL abort_idle_hs got busy %b want 1", busy); else passed++;
        abort = 1'b0; req_valid = '0;
      end
      if (done !== '0) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL abort_next_done unexpected %b at edge %0d", done, cyc + 1);
        else begin
          e = exp_q.pop_front(); oh = '0; oh[e.id] = 1'b1;
          if (done !== oh || cyc + 1 != e.edge_no) $display("[TB] FAIL abort_next_done got %b@%0d want %b@%0d", done, cyc + 1, oh, e.edge_no);
          else passed++;
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin $display("[TB] FAIL abort_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end else passed++;
  endtask

  task automatic test_zero_len();
    exp_t e; logic [NumReq-1:0] oh;
    req_valid = 4'b0100; req_len = '0;
    #1;
    checks++; if (req_ready !== 4'b0100) $display("[TB] FAIL zero_ready got %b want 0100", req_ready); else passed++;
    exp_q.push_back('{id: 2, edge_no: cyc + 2});
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) begin
        checks++; if (busy !== 1'b1) $display("[TB] FAIL zero_busy got %b want 1", busy); else passed++;
        req_valid = '0;
      end
      if (k == 1) begin
        checks++; if (busy !== 1'b0) $display("[TB] FAIL zero_idle got busy %b want 0", busy); else passed++;
      end
      checks++; if (count !== '0) $display("[TB] FAIL zero_count k=%0d got %0d want 0", k, count); else passed++;
      if (done !== '0) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL zero_done unexpected %b at edge %0d", done, cyc + 1);
        else begin
          e = exp_q.pop_front(); oh = '0; oh[e.id] = 1'b1;
          if (done !== oh || cyc + 1 != e.edge_no) $display("[TB] FAIL zero_done got %b@%0d want %b@%0d", done, cyc + 1, oh, e.edge_no);
          else passed++;
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin $display("[TB] FAIL zero_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end else passed++;
  endtask

  task automatic test_max_len();
    exp_t e; logic [NumReq-1:0] oh; logic [Width-1:0] exp_cnt;
    req_valid = 4'b1000; req_len = '0; req_len[3*Width +: Width] = 8'd255;
    #1;
    checks++; if (req_ready !== 4'b1000) $display("[TB] FAIL max_ready got %b want 1000", req_ready); else passed++;
    exp_q.push_back('{id: 3, edge_no: cyc + 1 + 256});
    for (int k = 0; k < 260; k++) begin
      tick();
      if (k == 0) req_valid = '0;
      if (k <= 256) begin
        exp_cnt = (k < 255) ? Width'(255 - k) : '0;
        checks++; if (count !== exp_cnt) $display("[TB] FAIL max_count k=%0d got %0d want %0d", k, count, exp_cnt); else passed++;
      end
      if (k == 256) begin
        checks++; if (busy !== 1'b0) $display("[TB] FAIL max_idle got busy %b want 0", busy); else passed++;
      end
      if (done !== '0) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL max_done unexpected %b at edge %0d", done, cyc + 1);
        else begin
          e = exp_q.pop_front(); oh = '0; oh[e.id] = 1'b1;
          if (done !== oh || cyc + 1 != e.edge_no) $display("[TB] FAIL max_done got %b@%0d want %b@%0d", done, cyc + 1, oh, e.edge_no);
          else passed++;
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin $display("[TB] FAIL max_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end else passed++;
  endtask

  task automatic test_round_robin();
    exp_t e; logic [NumReq-1:0] oh;
    req_valid = 4'b1111;
    for (int i = 0; i < NumReq; i++) req_len[i*Width +: Width] = 8'd2;
    #1;
    checks++; if (req_ready !== 4'b0001) $display("[TB] FAIL rr_ready got %b want 0001", req_ready); else passed++;
    for (int g = 0; g < 5; g++) exp_q.push_back('{id: g % 4, edge_no: cyc + 1 + 4*g + 3});
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k % 4 == 0) begin
        checks++; if (grant_id !== IdxW'((k/4) % 4)) $display("[TB] FAIL rr_grant n=%0d got %0d want %0d", k/4, grant_id, (k/4) % 4); else passed++;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL rr_busy n=%0d got %b want 1", k/4, busy); else passed++;
      end
      if (k == 16) req_valid = '0;
      if (done !== '0) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL rr_done unexpected %b at edge %0d", done, cyc + 1);
        else begin
          e = exp_q.pop_front(); oh = '0; oh[e.id] = 1'b1;
          if (done !== oh || cyc + 1 != e.edge_no) $display("[TB] FAIL rr_done got %b@%0d want %b@%0d", done, cyc + 1, oh, e.edge_no);
          else passed++;
        end
      end
    end
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rr_idle got busy %b want 0", busy); else passed++;
    checks++; if (exp_q.size() != 0) begin $display("[TB] FAIL rr_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end else passed++;
  endtask

  task automatic test_abort_in_done();
    exp_t e; logic [NumReq-1:0] oh;
    req_valid = 4'b0100; req_len = '0;
    tick();
    checks++; if (busy !== 1'b1) $display("[TB] FAIL adone_busy got %b want 1", busy); else passed++;
    abort = 1'b1; req_valid = '0;
    #1;
    checks++; if (done !== '0) $display("[TB] FAIL adone_done got %b want 0", done); else passed++;
    tick();
    checks++; if (busy !== 1'b0) $display("[TB] FAIL adone_idle got busy %b want 0", busy); else passed++;
    abort = 1'b0;
    // Owner of the aborted interval must not have become the last grant.
    req_valid = 4'b0101;
    #1;
    checks++; if (req_ready !== 4'b0100) $display("[TB] FAIL adone_next_ready got %b want 0100", req_ready); else passed++;
    exp_q.push_back('{id: 2, edge_no: cyc + 2});
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 0) req_valid = '0;
      if (done !== '0) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL adone_done2 unexpected %b at edge %0d", done, cyc + 1);
        else begin
          e = exp_q.pop_front(); oh = '0; oh[e.id] = 1'b1;
          if (done !== oh || cyc + 1 != e.edge_no) $display("[TB] FAIL adone_done2 got %b@%0d want %b@%0d", done, cyc + 1, oh, e.edge_no);
          else passed++;
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin $display("[TB] FAIL adone_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end else passed++;
  endtask

  task automatic test_reset_mid_run();
    exp_t e; logic [NumReq-1:0] oh;
    req_valid = 4'b1000; req_len = '0; req_len[3*Width +: Width] = 8'd9;
    tick();
    req_valid = '0;
    repeat (4) tick();
    checks++; if (count !== 8'd5) $display("[TB] FAIL midrst_pre_count got %0d want 5", count); else passed++;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy got %b want 0", busy); else passed++;
    checks++; if (count !== '0) $display("[TB] FAIL midrst_count got %0d want 0", count); else passed++;
    checks++; if (grant_id !== '0) $display("[TB] FAIL midrst_grant got %0d want 0", grant_id); else passed++;
    checks++; if (done !== '0) $display("[TB] FAIL midrst_done got %b want 0", done); else passed++;
    tick();
    checks++; if (done !== '0) $display("[TB] FAIL midrst_hold_done got %b want 0", done); else passed++;
    reset = 1'b1;
    req_valid = 4'b1001; req_len[0*Width +: Width] = 8'd1; req_len[3*Width +: Width] = 8'd1;
    #1;
    checks++; if (req_ready !== 4'b0001) $display("[TB] FAIL midrst_ready got %b want 0001", req_ready); else passed++;
    exp_q.push_back('{id: 0, edge_no: cyc + 3});
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) begin
        checks++; if (grant_id !== 2'd0) $display("[TB] FAIL midrst_grant0 got %0d want 0", grant_id); else passed++;
        req_valid = '0;
      end
      if (done !== '0) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL midrst_done2 unexpected %b at edge %0d", done, cyc + 1);
        else begin
          e = exp_q.pop_front(); oh = '0; oh[e.id] = 1'b1;
          if (done !== oh || cyc + 1 != e.edge_no) $display("[TB] FAIL midrst_done2 got %b@%0d want %b@%0d", done, cyc + 1, oh, e.edge_no);
          else passed++;
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin $display("[TB] FAIL midrst_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end else passed++;
  endtask

  initial begin
    test_reset();
    test_first_priority();
    test_single();
    test_abort();
    test_zero_len();
    test_max_len();
    test_round_robin();
    test_abort_in_done();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter NumReq, default 4, number of requesters sharing the interval counter (2..16).
REQ-002 Parameter Width, default 8, interval counter width in bits.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  NumReq  per-requester interval request.
REQ-007 req_len  input  NumReq*Width  packed interval lengths; requester i occupies bits [i*Width +: Width].
REQ-008 abort  input  1  cancels the interval in progress.
REQ-009 req_ready  output  NumReq  one-hot accept strobe; handshake completes when req_valid[i] and req_ready[i] are both 1.
REQ-010 done  output  NumReq  one-hot, one-cycle completion pulse to the owning requester.
REQ-011 busy  output  1  high in RUN and DONE.
REQ-012 grant_id  output  $clog2(NumReq)  index of the current or most recent owner.
REQ-013 count  output  Width  remaining cycles of the active interval.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE, req_ready SHALL be combinational: one-hot on the round-robin winner among asserted req_valid bits, or all-zero when none is asserted.
REQ-016 Round-robin search SHALL start at index (last_grant+1) mod NumReq and wrap at NumReq-1 to 0.
REQ-017 In RUN and DONE, req_ready SHALL be all-zero, and req_valid and req_len SHALL be ignored.
REQ-018 On handshake at edge T, the block SHALL capture grant_id and load count <= req_len[winner].
REQ-019 On handshake at edge T, the state SHALL go to RUN if len >= 1, or to DONE if len == 0.
REQ-020 In RUN, count SHALL decrement by 1 per cycle; when count == 1, next state SHALL be DONE and count SHALL become 0.
REQ-021 count SHALL never wrap below 0.
REQ-022 In DONE, done[grant_id] SHALL be 1 for exactly one cycle; next state SHALL be IDLE, with last_grant <= grant_id.
REQ-023 Latency: the done pulse SHALL occur in cycle T+len+1 for len >= 1, and in cycle T+1 for len == 0.
REQ-024 Consecutive grants SHALL be separated by at least one IDLE cycle, giving a minimum period of len+2 cycles.
REQ-025 abort high in RUN or DONE SHALL force IDLE and count <= 0, suppress the done pulse, and leave last_grant unchanged.
REQ-026 abort in IDLE SHALL have no effect and SHALL NOT block a handshake in that cycle.
REQ-027 abort together with count == 1 in RUN SHALL take priority: no done pulse is issued.
REQ-028 A requester that deasserts req_valid before being granted SHALL simply lose eligibility; no request state is stored.
REQ-029 busy SHALL equal (state != IDLE).
REQ-030 done and req_ready SHALL never have more than one bit set.

Reset
REQ-031 While reset == 0, the block SHALL hold state = IDLE, count = 0, grant_id = 0, done = 0, busy = 0 and last_grant = NumReq-1, so that requester 0 has first priority.
REQ-032 Reset asserted mid-interval SHALL abandon the interval immediately, without a done pulse.
REQ-033 Reset deassertion SHALL be synchronized externally; the block SHALL NOT contain a reset synchronizer.

Structure
REQ-034 Package counter_arbiter_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the default NumReq and Width constants.
REQ-035 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs: request vector, last_grant; outputs: one-hot grant, grant index, any).
REQ-036 The down-counter and FSM SHALL reside in counter_arbiter; no other sub-modules SHALL be used.

Verification
REQ-037 Reset mid-RUN with count = 5 -> all outputs 0 in the same cycle; after release, request on valid[3] with valid[0] also high -> requester 0 granted first.
REQ-038 Single request, requester 1, len = 3, handshake at T -> busy from T+1; count 3,2,1; done[1] at T+4; IDLE at T+5.
REQ-039 All four requesters continuously valid, len = 2 -> grant order 0,1,2,3,0; each done 3 cycles after its grant; grants 4 cycles apart.
REQ-040 len = 0 on requester 2 -> DONE directly; done[2] at T+1; count stays 0.
REQ-041 len = 255 (Width = 8) -> done at T+256, with no count wrap-around.
REQ-042 abort at count == 1 on requester 1 -> no done pulse; IDLE next cycle; the next grant with valid[1] and valid[2] high goes to 2.
